// File: rtl/mdio_phy_manager.sv
// mdio_phy_manager
// Owns the MDIO controller request port. After power-up it runs the PHY
// init sequence (soft reset, reset-done poll, advertisement, autoneg
// restart) and then polls BMSR periodically to report link state.
// Optional feature macro: MDIO_HOST_PORT_EN adds a host access port that
// shares the controller with the poller once init has completed.
module mdio_phy_manager #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PWRUP_CYCLES = 16'd50000,
  parameter logic [23:0] POLL_CYCLES  = 24'd1000000,
  parameter logic [7:0]  RST_RETRY    = 8'd16,
  parameter logic [15:0] ANAR_VAL     = 16'h01E1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mdio_start,
  output logic        mdio_mode,
  output logic [4:0]  mdio_addr,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wdata,
  input  logic [15:0] mdio_rdata,
  input  logic        mdio_done,
`ifdef MDIO_HOST_PORT_EN
  input  logic        host_req,
  input  logic        host_mode,
  input  logic [4:0]  host_reg_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
`endif
  output logic        init_done,
  output logic        init_err,
  output logic        link_up,
  output logic [15:0] phy_status
);

  // Each transaction state pulses the request on entry and then waits
  // there for the completion edge of the controller's done level.
  typedef enum logic [3:0] {
    S_PWRUP,
    S_WR_RST,
    S_RD_RST,
    S_WR_ANAR,
    S_WR_AN,
    S_RD_BMSR,
    S_IDLE,
    S_HOST,
    S_ERROR
  } state_t;

  localparam logic [23:0] PWRUP_LOAD = {8'd0, PWRUP_CYCLES} - 24'd1;
  localparam logic [23:0] POLL_LAST  = POLL_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        mode_q, mode_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic        init_done_q, init_done_d;
  logic        init_err_q, init_err_d;
  logic        link_up_q, link_up_d;
  logic [15:0] phy_status_q, phy_status_d;
`ifdef MDIO_HOST_PORT_EN
  logic        host_ack_q, host_ack_d;
  logic [15:0] host_rdata_q, host_rdata_d;
`endif

  logic        done_edge;
  logic        issue;
  logic        issue_mode;
  logic [4:0]  issue_reg;
  logic [15:0] issue_wdata;

  // Completion is only ever the rising edge of the controller's done level.
  assign done_edge = mdio_done & ~done_q;

  // Next-state, counters and request fields for the init/poll sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    done_d       = mdio_done;
    init_done_d  = init_done_q;
    init_err_d   = init_err_q;
    link_up_d    = link_up_q;
    phy_status_d = phy_status_q;
    issue        = 1'b0;
    issue_mode   = 1'b0;
    issue_reg    = 5'd0;
    issue_wdata  = 16'h0000;
`ifdef MDIO_HOST_PORT_EN
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
`endif

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 24'd0) begin
          state_d     = S_WR_RST;
          issue       = 1'b1;
          issue_wdata = 16'h8000;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_WR_RST: begin
        if (done_edge) begin
          state_d    = S_RD_RST;
          issue      = 1'b1;
          issue_mode = 1'b1;
        end
      end
      S_RD_RST: begin
        if (done_edge) begin
          if (!mdio_rdata[15]) begin
            state_d     = S_WR_ANAR;
            issue       = 1'b1;
            issue_reg   = 5'd4;
            issue_wdata = ANAR_VAL;
          end else if (retry_q + 8'd1 == RST_RETRY) begin
            retry_d    = retry_q + 8'd1;
            init_err_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            retry_d    = retry_q + 8'd1;
            issue      = 1'b1;
            issue_mode = 1'b1;
          end
        end
      end
      S_WR_ANAR: begin
        if (done_edge) begin
          state_d     = S_WR_AN;
          issue       = 1'b1;
          issue_wdata = 16'h1200;
        end
      end
      S_WR_AN: begin
        if (done_edge) begin
          init_done_d = 1'b1;
          state_d     = S_RD_BMSR;
          issue       = 1'b1;
          issue_mode  = 1'b1;
          issue_reg   = 5'd1;
        end
      end
      S_RD_BMSR: begin
        if (done_edge) begin
          phy_status_d = mdio_rdata;
          link_up_d    = mdio_rdata[2];
          cnt_d        = 24'd0;
          state_d      = S_IDLE;
        end
      end
      S_IDLE: begin
`ifdef MDIO_HOST_PORT_EN
        if (host_req && !host_ack_q) begin
          state_d     = S_HOST;
          issue       = 1'b1;
          issue_mode  = host_mode;
          issue_reg   = host_reg_addr;
          issue_wdata = host_mode ? 16'h0000 : host_wdata;
        end else
`endif
        if (cnt_q == POLL_LAST) begin
          state_d    = S_RD_BMSR;
          issue      = 1'b1;
          issue_mode = 1'b1;
          issue_reg  = 5'd1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
`ifdef MDIO_HOST_PORT_EN
      S_HOST: begin
        if (done_edge) begin
          host_ack_d = 1'b1;
          if (mode_q) begin
            host_rdata_d = mdio_rdata;
          end
          state_d = S_IDLE;
        end
      end
`endif
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_PWRUP;
      end
    endcase

    start_d = issue;
    mode_d  = issue ? issue_mode : mode_q;
    addr_d  = issue ? PHY_ADDR : addr_q;
    reg_d   = issue ? issue_reg : reg_q;
    wdata_d = issue ? issue_wdata : wdata_q;
  end

  // State and output registers; reset aborts any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWRUP;
      cnt_q        <= PWRUP_LOAD;
      retry_q      <= 8'd0;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      addr_q       <= 5'd0;
      reg_q        <= 5'd0;
      wdata_q      <= 16'h0000;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      link_up_q    <= 1'b0;
      phy_status_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      done_q       <= done_d;
      start_q      <= start_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      init_done_q  <= init_done_d;
      init_err_q   <= init_err_d;
      link_up_q    <= link_up_d;
      phy_status_q <= phy_status_d;
    end
  end

`ifdef MDIO_HOST_PORT_EN
  // Host acknowledge pulse and last host read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_ack_q   <= 1'b0;
      host_rdata_q <= 16'h0000;
    end else begin
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
`endif

  assign mdio_start    = start_q;
  assign mdio_mode     = mode_q;
  assign mdio_addr     = addr_q;
  assign mdio_reg_addr = reg_q;
  assign mdio_wdata    = wdata_q;
  assign init_done     = init_done_q;
  assign init_err      = init_err_q;
  assign link_up       = link_up_q;
  assign phy_status    = phy_status_q;

endmodule

// File: tb/tb_mdio_phy_manager.sv
// tb_mdio_phy_manager
// Drives mdio_phy_manager against a small MDIO controller/PHY model.
// Expected transactions are queued when a scenario starts and compared as
// the DUT issues requests. Host-port scenarios build when MDIO_HOST_PORT_EN
// is defined.
module tb_mdio_phy_manager;

  localparam logic [4:0]  PHY   = 5'd1;
  localparam logic [15:0] PWRUP = 16'd8;
  localparam logic [23:0] POLL  = 24'd100;
  localparam logic [7:0]  RETRY = 8'd4;
  localparam logic [15:0] ANAR  = 16'h01E1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdio_start;
  logic        mdio_mode;
  logic [4:0]  mdio_addr;
  logic [4:0]  mdio_reg_addr;
  logic [15:0] mdio_wdata;
  logic [15:0] mdio_rdata = 16'h0000;
  logic        mdio_done = 1'b0;
  logic        init_done;
  logic        init_err;
  logic        link_up;
  logic [15:0] phy_status;
`ifdef MDIO_HOST_PORT_EN
  logic        host_req = 1'b0;
  logic        host_mode = 1'b0;
  logic [4:0]  host_reg_addr = 5'd0;
  logic [15:0] host_wdata = 16'h0000;
  logic        host_ack;
  logic [15:0] host_rdata;
`endif

  mdio_phy_manager #(
    .PHY_ADDR(PHY), .PWRUP_CYCLES(PWRUP), .POLL_CYCLES(POLL),
    .RST_RETRY(RETRY), .ANAR_VAL(ANAR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mdio_start(mdio_start), .mdio_mode(mdio_mode), .mdio_addr(mdio_addr),
    .mdio_reg_addr(mdio_reg_addr), .mdio_wdata(mdio_wdata),
    .mdio_rdata(mdio_rdata), .mdio_done(mdio_done),
`ifdef MDIO_HOST_PORT_EN
    .host_req(host_req), .host_mode(host_mode), .host_reg_addr(host_reg_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
`endif
    .init_done(init_done), .init_err(init_err), .link_up(link_up),
    .phy_status(phy_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] bmcr_q[$];
  logic [15:0] bmsr_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic        busy = 1'b0;
  int          lat = 0;
  logic [15:0] resp = 16'h0000;
  logic        cur_mode = 1'b0;
  logic [4:0]  cur_reg = 5'd0;
  int          n_starts = 0;
  int          first_start_cyc = -1;
  int          last_bmsr_done = -1;
  int          bmsr_start_cyc = -1;
  int          bmsr_gap = -1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  task automatic nextSample();
    @(negedge clk);
    #1;
  endtask

  task automatic pushTxn(input logic mode, input logic [4:0] reg_addr, input logic [15:0] wdata);
    txn_t t;
    t.mode = mode;
    t.reg_addr = reg_addr;
    t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    n_starts = 0;
    first_start_cyc = -1;
    last_bmsr_done = -1;
    bmsr_start_cyc = -1;
    bmsr_gap = -1;
    repeat (3) nextSample();
  endtask

  // Queue the expected init sequence, prime the BMCR responses, release reset.
  task automatic applyStimulus(input bit stuck, input int n_busy);
    exp_q.delete();
    bmcr_q.delete();
    pushTxn(1'b0, 5'd0, 16'h8000);
    if (stuck) begin
      for (int i = 0; i < int'(RETRY); i++) begin
        pushTxn(1'b1, 5'd0, 16'h0000);
        bmcr_q.push_back(16'h8000);
      end
    end else begin
      for (int i = 0; i < n_busy; i++) begin
        pushTxn(1'b1, 5'd0, 16'h0000);
        bmcr_q.push_back(16'h8000);
      end
      pushTxn(1'b1, 5'd0, 16'h0000);
      bmcr_q.push_back(16'h1000);
      pushTxn(1'b0, 5'd4, ANAR);
      pushTxn(1'b0, 5'd0, 16'h1200);
      pushTxn(1'b1, 5'd1, 16'h0000);
    end
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic waitModelIdle(input int budget, input string tag);
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && !busy) && i < budget) begin
      nextSample();
      i++;
    end
    if (i >= budget) checkOutput(tag, {exp_q.size(), busy}, 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller + PHY model: done drops on start, rises 4 cycles later with read data.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy = 1'b0;
      lat = 0;
      mdio_done = 1'b0;
    end else begin
      if (busy) begin
        if (lat == 0) begin
          mdio_rdata = resp;
          mdio_done = 1'b1;
          busy = 1'b0;
          if (cur_mode && cur_reg == 5'd1) last_bmsr_done = cyc;
        end else begin
          lat--;
        end
      end
      if (mdio_start) begin
        txn_t e;
        checkOutput("start_while_busy", busy, 1'b0);
        checkOutput("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
        checkOutput("mdio_addr", mdio_addr, PHY);
        if (n_starts == 0) first_start_cyc = cyc;
        n_starts++;
        if (mdio_mode && mdio_reg_addr == 5'd1) begin
          if (last_bmsr_done >= 0) bmsr_gap = cyc - last_bmsr_done;
          bmsr_start_cyc = cyc;
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.mode) checkOutput("txn_read", {mdio_mode, mdio_reg_addr}, {e.mode, e.reg_addr});
          else checkOutput("txn_write", {mdio_mode, mdio_reg_addr, mdio_wdata}, {e.mode, e.reg_addr, e.wdata});
        end
        if (mdio_mode && mdio_reg_addr == 5'd0) resp = (bmcr_q.size() != 0) ? bmcr_q.pop_front() : 16'h1000;
        else if (mdio_mode && mdio_reg_addr == 5'd1) resp = (bmsr_q.size() != 0) ? bmsr_q.pop_front() : 16'h782D;
        else resp = 16'h0020 | {11'd0, mdio_reg_addr};
        cur_mode = mdio_mode;
        cur_reg = mdio_reg_addr;
        busy = 1'b1;
        lat = 3;
        mdio_done = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k2;
    doReset();
    checkOutput("rst_start", mdio_start, 1'b0);
    checkOutput("rst_init_done", init_done, 1'b0);
    checkOutput("rst_init_err", init_err, 1'b0);
    checkOutput("rst_link_up", link_up, 1'b0);
    checkOutput("rst_phy_status", phy_status, 16'h0000);
    checkOutput("rst_reg_addr", mdio_reg_addr, 5'd0);
`ifdef MDIO_HOST_PORT_EN
    checkOutput("rst_host_ack", host_ack, 1'b0);
    checkOutput("rst_host_rdata", host_rdata, 16'h0000);
`endif

    // Init with two busy BMCR reads, then the first poll.
    $display("[TB] init sequence with reset-done retries");
    bmsr_q.delete();
    bmsr_q.push_back(16'h782D);
    bmsr_q.push_back(16'h7809);
    applyStimulus(1'b0, 2);
    waitModelIdle(1000, "init_timeout");
    repeat (3) nextSample();
    checkOutput("first_start_cycle", first_start_cyc - rel_cyc, 32'(PWRUP));
    checkOutput("init_done", init_done, 1'b1);
    checkOutput("init_err", init_err, 1'b0);
    checkOutput("link_up_first", link_up, 1'b1);
    checkOutput("phy_status_first", phy_status, 16'h782D);

    // Periodic poll; the done edge takes one cycle to register, then POLL idle cycles.
    $display("[TB] periodic BMSR poll");
    pushTxn(1'b1, 5'd1, 16'h0000);
    repeat (50) nextSample();
    checkOutput("link_up_stable", link_up, 1'b1);
    checkOutput("phy_status_stable", phy_status, 16'h782D);
    waitModelIdle(400, "poll_timeout");
    repeat (3) nextSample();
    checkOutput("poll_gap", bmsr_gap, 32'(POLL) + 32'd1);
    checkOutput("link_up_second", link_up, 1'b0);
    checkOutput("phy_status_second", phy_status, 16'h7809);

`ifdef MDIO_HOST_PORT_EN
    // Host read of reg 2 raised exactly as the poll counter expires.
    begin
      int ack_cyc;
      $display("[TB] host read coincident with poll expiry");
      k2 = last_bmsr_done;
      pushTxn(1'b1, 5'd2, 16'h0000);
      pushTxn(1'b1, 5'd1, 16'h0000);
      while (cyc < k2 + int'(POLL)) nextSample();
      host_mode = 1'b1;
      host_reg_addr = 5'd2;
      host_req = 1'b1;
      ack_cyc = -1;
      for (int i = 0; i < 50; i++) begin
        nextSample();
        if (host_ack) begin
          ack_cyc = cyc;
          break;
        end
      end
      host_req = 1'b0;
      checkOutput("host_ack_seen", ack_cyc >= 0, 1'b1);
      checkOutput("host_rdata", host_rdata, 16'h0022);
      nextSample();
      checkOutput("host_ack_pulse", host_ack, 1'b0);
      waitModelIdle(50, "host_poll_timeout");
      repeat (3) nextSample();
      checkOutput("bmsr_after_host", bmsr_start_cyc - ack_cyc, 32'd1);
      checkOutput("link_up_after_host", link_up, 1'b1);
    end
`endif

    // Reset while the ANAR write is outstanding, then a full re-init.
    $display("[TB] reset during WR_ANAR wait");
    doReset();
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 300 && !(busy && cur_reg == 5'd4 && !cur_mode); i++) nextSample();
    checkOutput("reach_wr_anar", {busy, cur_mode, cur_reg}, {1'b1, 1'b0, 5'd4});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_start", mdio_start, 1'b0);
    checkOutput("abort_reg_addr", mdio_reg_addr, 5'd0);
    checkOutput("abort_wdata", mdio_wdata, 16'h0000);
    checkOutput("abort_addr", mdio_addr, 5'd0);
    checkOutput("abort_init_done", init_done, 1'b0);
    doReset();
    applyStimulus(1'b0, 0);
    waitModelIdle(1000, "reinit_timeout");
    repeat (3) nextSample();
    checkOutput("reinit_first_start", first_start_cyc - rel_cyc, 32'(PWRUP));
    checkOutput("reinit_done", init_done, 1'b1);
    checkOutput("reinit_link_up", link_up, 1'b1);

    // BMCR never clears: retries exhaust and all traffic stops.
    $display("[TB] reset-done poll exhaustion");
    doReset();
    applyStimulus(1'b1, 0);
    waitModelIdle(1000, "err_timeout");
`ifdef MDIO_HOST_PORT_EN
    host_mode = 1'b1;
    host_reg_addr = 5'd2;
    host_req = 1'b1;
    begin
      int n_acks;
      n_acks = 0;
      for (int i = 0; i < 200; i++) begin
        nextSample();
        if (host_ack) n_acks++;
      end
      checkOutput("err_host_no_ack", n_acks, 32'd0);
    end
    host_req = 1'b0;
`else
    repeat (200) nextSample();
`endif
    checkOutput("err_init_err", init_err, 1'b1);
    checkOutput("err_init_done", init_done, 1'b0);
    checkOutput("err_start_count", n_starts, 32'd1 + 32'(RETRY));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
